// File: rtl/cal_level_capture.sv
// cal_level_capture
// Captures four signed sample channels on each rising edge of sample_clk
// (detected in the clk domain), averages 2^LOG2N consecutive samples per
// channel and presents the four means through a valid/ready handshake.
// A capture is requested with a single-cycle start pulse; the first partial
// sample period after start is discarded so every capture spans whole periods.
//
// Optional feature: define CAL_LEVEL_CAPTURE_MINMAX_EN to add per-channel
// min/max outputs (min0..3, max0..3) tracked over the same counted samples
// and registered alongside the means.
module cal_level_capture #(
   parameter int W     = 16,
   parameter int LOG2N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_clk,
   input  logic signed [W-1:0] sample_in0,
   input  logic signed [W-1:0] sample_in1,
   input  logic signed [W-1:0] sample_in2,
   input  logic signed [W-1:0] sample_in3,
   input  logic                start,
   output logic                busy,
   output logic                result_valid,
   input  logic                result_ready,
   output logic signed [W-1:0] mean0,
   output logic signed [W-1:0] mean1,
   output logic signed [W-1:0] mean2,
   output logic signed [W-1:0] mean3
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
   ,
   output logic signed [W-1:0] min0,
   output logic signed [W-1:0] min1,
   output logic signed [W-1:0] min2,
   output logic signed [W-1:0] min3,
   output logic signed [W-1:0] max0,
   output logic signed [W-1:0] max1,
   output logic signed [W-1:0] max2,
   output logic signed [W-1:0] max3
`endif
);

   // Accumulator is wide enough that 2^LOG2N full-scale samples cannot overflow.
   localparam int AW = W + LOG2N;
   localparam int CW = LOG2N + 1;
   // Count value at which the next tick completes the capture.
   localparam logic [CW-1:0] LAST_COUNT = {1'b0, {LOG2N{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_ACCUM,
      S_DONE,
      S_HOLD
   } state_t;

   state_t               state;
   logic                 sclk_q;
   logic                 tick;
   logic [CW-1:0]        count;
   logic signed [W-1:0]  smp    [4];
   logic signed [AW-1:0] acc    [4];
   logic signed [W-1:0]  mean_q [4];
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
   logic signed [W-1:0]  run_min [4];
   logic signed [W-1:0]  run_max [4];
   logic signed [W-1:0]  min_q   [4];
   logic signed [W-1:0]  max_q   [4];
`endif

   assign smp[0] = sample_in0;
   assign smp[1] = sample_in1;
   assign smp[2] = sample_in2;
   assign smp[3] = sample_in3;

   // sample_clk is synchronous to clk, so a single register suffices for edge detection.
   assign tick = sample_clk & ~sclk_q;

   // Delay sample_clk by one clk to find its 0->1 transitions.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent logic.
      if (rst) sclk_q <= 1'b0;
      else     sclk_q <= sample_clk;
   end

   // Capture FSM: arm on start, accumulate 2^LOG2N ticks, publish means, hold until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         count        <= '0;
         // NOTE: the small accumulator/mean arrays are reset explicitly because an
         // aborted capture must leave no residue; large RAM-style arrays would not be.
         for (int i = 0; i < 4; i++) begin
            acc[i]    <= '0;
            mean_q[i] <= '0;
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
            run_min[i] <= '0;
            run_max[i] <= '0;
            min_q[i]   <= '0;
            max_q[i]   <= '0;
`endif
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ARM;
                  busy  <= 1'b1;
                  count <= '0;
                  for (int i = 0; i < 4; i++) acc[i] <= '0;
               end
            end

            // Wait for a fresh sample edge so a partial period is never counted.
            S_ARM: begin
               if (tick) begin
                  state <= S_ACCUM;
                  count <= CW'(1);
                  for (int i = 0; i < 4; i++) begin
                     acc[i] <= AW'(smp[i]);
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
                     run_min[i] <= smp[i];
                     run_max[i] <= smp[i];
`endif
                  end
               end
            end

            S_ACCUM: begin
               if (tick) begin
                  count <= count + CW'(1);
                  for (int i = 0; i < 4; i++) begin
                     acc[i] <= acc[i] + AW'(smp[i]);
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
                     if (smp[i] < run_min[i]) run_min[i] <= smp[i];
                     if (smp[i] > run_max[i]) run_max[i] <= smp[i];
`endif
                  end
                  if (count == LAST_COUNT) state <= S_DONE;
               end
            end

            // Dropping the low LOG2N bits of a signed sum is an arithmetic
            // shift, i.e. the mean rounds toward minus infinity.
            S_DONE: begin
               for (int i = 0; i < 4; i++) begin
                  mean_q[i] <= acc[i][AW-1:LOG2N];
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
                  min_q[i] <= run_min[i];
                  max_q[i] <= run_max[i];
`endif
               end
               result_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= S_HOLD;
            end

            // Results stay frozen until consumed; start is ignored here.
            S_HOLD: begin
               if (result_valid && result_ready) begin
                  result_valid <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign mean0 = mean_q[0];
   assign mean1 = mean_q[1];
   assign mean2 = mean_q[2];
   assign mean3 = mean_q[3];

`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
   assign min0 = min_q[0];
   assign min1 = min_q[1];
   assign min2 = min_q[2];
   assign min3 = min_q[3];
   assign max0 = max_q[0];
   assign max1 = max_q[1];
   assign max2 = max_q[2];
   assign max3 = max_q[3];
`endif

endmodule

// File: tb/tb_cal_level_capture.sv
// Testbench for cal_level_capture (LOG2N=4). Stimulus pushes hand-computed
// expected results into a scoreboard; a monitor pops and compares them on each
// result handshake. Min/max are compared when CAL_LEVEL_CAPTURE_MINMAX_EN is set.
module tb_cal_level_capture;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                sample_clk;
   logic                start;
   logic                result_ready;
   logic signed [W-1:0] in0, in1, in2, in3;
   logic                busy;
   logic                result_valid;
   logic signed [W-1:0] mean0, mean1, mean2, mean3;
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
   logic signed [W-1:0] min0, min1, min2, min3;
   logic signed [W-1:0] max0, max1, max2, max3;
`endif

   typedef struct packed {
      logic [3:0][W-1:0] mean;
      logic [3:0][W-1:0] lo;
      logic [3:0][W-1:0] hi;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   cal_level_capture #(.W(W), .LOG2N(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_clk   (sample_clk),
      .sample_in0   (in0),
      .sample_in1   (in1),
      .sample_in2   (in2),
      .sample_in3   (in3),
      .start        (start),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .mean0        (mean0),
      .mean1        (mean1),
      .mean2        (mean2),
      .mean3        (mean3)
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
      ,
      .min0         (min0),
      .min1         (min1),
      .min2         (min2),
      .min3         (min3),
      .max0         (max0),
      .max1         (max1),
      .max2         (max2),
      .max3         (max3)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int m0, m1, m2, m3,
                           input int l0, l1, l2, l3,
                           input int h0, h1, h2, h3);
      exp_t e;
      e.mean[0] = W'(m0); e.mean[1] = W'(m1); e.mean[2] = W'(m2); e.mean[3] = W'(m3);
      e.lo[0]   = W'(l0); e.lo[1]   = W'(l1); e.lo[2]   = W'(l2); e.lo[3]   = W'(l3);
      e.hi[0]   = W'(h0); e.hi[1]   = W'(h1); e.hi[2]   = W'(h2); e.hi[3]   = W'(h3);
      sb_q.push_back(e);
   endtask

   // Monitor: compare outputs against the scoreboard on every accepted result.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst && result_valid && result_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got mean0=%0d, expected no result", mean0);
         end else begin
            e = sb_q.pop_front();
            check("mean0", mean0, $signed(e.mean[0]));
            check("mean1", mean1, $signed(e.mean[1]));
            check("mean2", mean2, $signed(e.mean[2]));
            check("mean3", mean3, $signed(e.mean[3]));
`ifdef CAL_LEVEL_CAPTURE_MINMAX_EN
            check("min0", min0, $signed(e.lo[0]));
            check("min1", min1, $signed(e.lo[1]));
            check("min2", min2, $signed(e.lo[2]));
            check("min3", min3, $signed(e.lo[3]));
            check("max0", max0, $signed(e.hi[0]));
            check("max1", max1, $signed(e.hi[1]));
            check("max2", max2, $signed(e.hi[2]));
            check("max3", max3, $signed(e.hi[3]));
`endif
         end
      end
   end

   task automatic drive(input int a, b, c, d);
      in0 = W'(a); in1 = W'(b); in2 = W'(c); in3 = W'(d);
   endtask

   // One sample period: high for 2 clk, low for 2 clk (the next call adds one).
   task automatic tick(input int a, b, c, d);
      @(negedge clk);
      drive(a, b, c, d);
      sample_clk = 1'b1;
      repeat (2) @(negedge clk);
      sample_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      for (int c = 0; c < 200; c++) begin
         if (result_valid) break;
         @(negedge clk);
      end
      check(name, result_valid, 1);
   endtask

   task automatic accept();
      @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      sample_clk   = 1'b0;
      start        = 1'b0;
      result_ready = 1'b0;
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_mean0", mean0, 0);
      check("rst_mean1", mean1, 0);
      check("rst_mean2", mean2, 0);
      check("rst_mean3", mean3, 0);
      rst = 1'b0;

      // Reset mid-capture after 7 ticks: partial sum discarded, no result.
      pulse_start();
      for (int i = 0; i < 7; i++) tick(50, 50, 50, 50);
      check("accum_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", result_valid, 0);
      check("midrst_mean0", mean0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_valid", result_valid, 0);
      check("postrst_busy", busy, 0);

      // Fresh capture after reset completes normally.
      push_exp(1000, -1000, 7, -7, 1000, -1000, 7, -7, 1000, -1000, 7, -7);
      pulse_start();
      for (int i = 0; i < 16; i++) tick(1000, -1000, 7, -7);
      wait_valid("after_rst_valid");
      accept();

      // Calibration levels with result_valid latency check on the final tick.
      push_exp(4000, -4000, 0, 32767, 4000, -4000, 0, 32767, 4000, -4000, 0, 32767);
      pulse_start();
      for (int i = 0; i < 15; i++) tick(4000, -4000, 0, 32767);
      @(negedge clk);
      drive(4000, -4000, 0, 32767);
      sample_clk = 1'b1;
      @(negedge clk);
      check("lat1_valid", result_valid, 0);
      check("lat1_busy", busy, 1);
      @(negedge clk);
      check("lat2_valid", result_valid, 1);
      check("lat2_busy", busy, 0);
      sample_clk = 1'b0;
      wait_valid("levels_valid");
      accept();

      // Floor rounding: sums -8, -16, -15, +15 -> -1, -1, -1, 0.
      push_exp(-1, -1, -1, 0, -2, -1, -1, 0, 1, -1, 0, 1);
      pulse_start();
      for (int i = 0; i < 16; i++)
         tick((i % 2 == 0) ? 1 : -2, -1, (i == 0) ? 0 : -1, (i == 0) ? 0 : 1);
      wait_valid("floor_valid");
      accept();

      // Start coincident with a sample edge (not counted), then a start during ACCUM (ignored).
      push_exp(100, -50, -32768, 3, 100, -50, -32768, 3, 100, -50, -32768, 3);
      @(negedge clk);
      start = 1'b1;
      drive(30000, 30000, 30000, 30000);
      sample_clk = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      sample_clk = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick(100, -50, -32768, 3);
         if (i == 5) pulse_start();
      end
      wait_valid("midstart_valid");
      accept();

      // HOLD stability with ready low for 50 cycles and changing inputs.
      push_exp(200, 201, -202, 0, 200, 201, -202, 0, 200, 201, -202, 0);
      pulse_start();
      for (int i = 0; i < 16; i++) tick(200, 201, -202, 0);
      wait_valid("hold_valid");
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         drive(100, 100, 100, 100);
         sample_clk = (c % 4 < 2);
         check("hold_rv_stable", result_valid, 1);
         check("hold_mean0_stable", mean0, 200);
      end
      sample_clk = 1'b0;
      @(negedge clk);
      result_ready = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
      check("hold_drop_valid", result_valid, 0);
      check("hold_start_ignored", busy, 0);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_mean_kept", mean0, 200);

      // Ramps: mean -1 / 7500 / -8 / 5; min/max -8..7, 0..15000, -15..0.
      push_exp(-1, 7500, -8, 5, -8, 0, -15, 5, 7, 15000, 0, 5);
      pulse_start();
      for (int i = 0; i < 16; i++) tick(-8 + i, i * 1000, -i, 5);
      wait_valid("ramp_valid");
      accept();

      repeat (3) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
